// File: rtl/counter_param_pkg.sv
// Shared types and encodings for the parametrised up/down counter.
// Every file in the counter_param slice imports this package.
package counter_param_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: counts advance cycles 0..i_prescale and flags tick on the last one.
// Latency: tick is combinational from the stored count; no backpressure, advance is a plain strobe.
module counter_prescaler
  import counter_param_pkg::*;
#(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  advance,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = (cnt == i_prescale);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_param.sv
// WIDTH-bit up/down counter with enable, limit, wrap/saturate and load; prescaler under COUNTER_PARAM_PRESCALE_EN.
// Latency 1 cycle to o_count; no backpressure, i_clk_en=0 freezes all state.
module counter_param
  import counter_param_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_clk_en,
  input  logic                  i_count_valid,
  input  logic                  i_dir,
  input  logic                  i_mode,
  input  logic [WIDTH-1:0]      i_limit,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_load_value,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_count_end,
  output logic                  o_halted
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             count_end, end_nxt;
  logic             qualified, tick, step, at_term;

  assign qualified = i_clk_en & i_count_valid & (state == ST_RUN);

`ifdef COUNTER_PARAM_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .resetn     (resetn),
    .advance    (qualified & ~i_load),
    .clear      (i_clk_en & i_load),
    .i_prescale (i_prescale),
    .tick       (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^i_prescale;
  assign tick = 1'b1;
`endif

  assign step = qualified & tick & ~i_load;

  // Compare precedes the increment, so the up path can never overflow.
  assign at_term = (i_dir == DIR_DOWN) ? (count == '0) : (count >= i_limit);

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    end_nxt   = 1'b0;
    if (i_clk_en) begin
      if (i_load) begin
        count_nxt = i_load_value;
        state_nxt = ST_RUN;
      end else if (step) begin
        if (at_term) begin
          end_nxt = 1'b1;
          if (i_mode == MODE_SAT) begin
            state_nxt = ST_HALT;
          end else begin
            count_nxt = (i_dir == DIR_DOWN) ? i_limit : '0;
          end
        end else begin
          count_nxt = (i_dir == DIR_DOWN) ? count - 1'b1 : count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count     <= '0;
      count_end <= 1'b0;
      state     <= ST_RUN;
    end else begin
      count     <= count_nxt;
      count_end <= end_nxt;
      state     <= state_nxt;
    end
  end

  assign o_count     = count;
  assign o_count_end = count_end;
  assign o_halted    = (state == ST_HALT);

endmodule
